// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED running-light sequencer:
//   - mode_t        : pattern select encodings (SHIFT, BOUNCE, FILL, BLINK)
//   - PAT_*         : reference patterns used as initial/terminal states
//   - init_pat()    : initial pattern for a given mode/direction
// No ports (package).
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam logic [3:0] PAT_MSB  = 4'b1000;
    localparam logic [3:0] PAT_LSB  = 4'b0001;
    localparam logic [3:0] PAT_ALL  = 4'b1111;
    localparam logic [3:0] PAT_NONE = 4'b0000;

    // BLINK always starts fully lit; the others start at the end the
    // light travels away from (MSB for dir=0, LSB for dir=1).
    function automatic logic [3:0] init_pat(input mode_t m, input logic d);
        if (m == MODE_BLINK) begin
            return PAT_ALL;
        end
        return d ? PAT_LSB : PAT_MSB;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Step-rate divider for the LED sequencer. Produces a tick once every
// max(TICK_DIV >> SPEED, 1) enabled cycles.
// Ports:
//   CLK   in  1  system clock
//   RST   in  1  synchronous active-high reset (count to 0)
//   EN    in  1  1 = count, 0 = hold count, no tick
//   SPEED in  2  period divisor shift, sampled every cycle
//   clr   in  1  restart the count (pattern reload)
//   tick  out 1  combinational, high in the cycle the count expires
// Parameter: TICK_DIV = cycles per step at SPEED=0.
module led_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] SPEED,
    input  logic       clr,
    output logic       tick
);

    logic [31:0] cnt;
    logic [31:0] period;

    // Period clamps to 1 so a small TICK_DIV with a large SPEED still
    // steps every cycle instead of never.
    always_comb begin
        period = 32'(TICK_DIV) >> SPEED;
        if (period == 32'd0) begin
            period = 32'd1;
        end
    end

    // The >= compare makes a period shrink below the current count
    // fire on the next enabled cycle rather than wrapping.
    assign tick = EN && (cnt >= (period - 32'd1));

    // Count is held while paused so a resume continues where it left off.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (EN) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
// Pattern sequencer for the 4-LED running-light display. Steps one of
// SHIFT / BOUNCE / FILL / BLINK at a selectable rate, with run/pause,
// latched mode/direction and output polarity select.
// Ports:
//   CLK       in  1  system clock
//   RST       in  1  synchronous active-high reset
//   EN        in  1  1 = run, 0 = pause
//   MODE      in  2  pattern select, latched on MODE_LOAD
//   DIR       in  1  direction, latched on MODE_LOAD
//   MODE_LOAD in  1  latch MODE/DIR and restart the pattern
//   SPEED     in  2  step period = max(TICK_DIV >> SPEED, 1)
//   POL       in  1  1 = active-high LEDs, 0 = active-low
//   BRIGHT    in  3  brightness (only with LED_SEQ_PWM_EN defined)
//   LED       out 4  pattern with polarity applied (combinational)
//   STEP      out 1  registered pulse on the first cycle of a new pattern
// Optional feature macro: LED_SEQ_PWM_EN adds BRIGHT and a 3-bit PWM
// counter that gates lit LEDs to (BRIGHT+1)/8 duty.
module led_seq_ctrl #(
    parameter int TICK_DIV = 5000000,
    parameter int N_LED    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    input  logic             MODE_LOAD,
    input  logic [1:0]       SPEED,
    input  logic             POL,
`ifdef LED_SEQ_PWM_EN
    input  logic [2:0]       BRIGHT,
`endif
    output logic [N_LED-1:0] LED,
    output logic             STEP
);

    import led_seq_pkg::*;

    mode_t            mode_q;
    logic             dir_q;
    logic             bounce;
    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nxt;
    logic             bounce_nxt;
    logic             to_lsb;
    logic [N_LED-1:0] lit;
    logic             tick;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .SPEED (SPEED),
        .clr   (MODE_LOAD),
        .tick  (tick)
    );

    // Next-pattern logic. Any pattern that cannot occur in the current
    // mode falls back to that mode's initial pattern. For BOUNCE the
    // light travels toward the LSB when the bounce flag equals dir.
    always_comb begin
        pat_nxt    = init_pat(mode_q, dir_q);
        bounce_nxt = 1'b0;
        to_lsb     = (dir_q == bounce);
        case (mode_q)
            MODE_SHIFT: begin
                case (pat)
                    4'b1000, 4'b0100, 4'b0010, 4'b0001:
                        pat_nxt = dir_q ? {pat[2:0], pat[3]} : {pat[0], pat[3:1]};
                    default: ;
                endcase
            end
            MODE_BOUNCE: begin
                case (pat)
                    4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
                        if (pat != (to_lsb ? PAT_LSB : PAT_MSB)) begin
                            pat_nxt    = to_lsb ? (pat >> 1) : (pat << 1);
                            bounce_nxt = bounce;
                            if (pat_nxt == (to_lsb ? PAT_LSB : PAT_MSB)) begin
                                bounce_nxt = ~bounce;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            MODE_FILL: begin
                if (pat == PAT_ALL) begin
                    pat_nxt = PAT_NONE;
                end else if (!dir_q && (pat == 4'b1000 || pat == 4'b1100 || pat == 4'b1110)) begin
                    pat_nxt = {1'b1, pat[3:1]};
                end else if (dir_q && (pat == 4'b0001 || pat == 4'b0011 || pat == 4'b0111)) begin
                    pat_nxt = {pat[2:0], 1'b1};
                end
            end
            MODE_BLINK: begin
                pat_nxt = (pat == PAT_ALL) ? PAT_NONE : PAT_ALL;
            end
            default: ;
        endcase
    end

    // Pattern state: reset beats a reload, which beats a step. A reload
    // also suppresses STEP even when it lands on a tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= MODE_SHIFT;
            dir_q  <= 1'b0;
            bounce <= 1'b0;
            pat    <= PAT_MSB;
            STEP   <= 1'b0;
        end else if (MODE_LOAD) begin
            mode_q <= mode_t'(MODE);
            dir_q  <= DIR;
            bounce <= 1'b0;
            pat    <= init_pat(mode_t'(MODE), DIR);
            STEP   <= 1'b0;
        end else if (tick) begin
            pat    <= pat_nxt;
            bounce <= bounce_nxt;
            STEP   <= 1'b1;
        end else begin
            STEP   <= 1'b0;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [2:0] pwm_cnt;

    // Free-running PWM phase; lit LEDs only show during phases 0..BRIGHT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    assign lit = (pwm_cnt <= BRIGHT) ? pat : '0;
`else
    assign lit = pat;
`endif

    assign LED = lit ^ {N_LED{~POL}};

endmodule
